// File: rtl/b1_disc_sched_if.sv
// Signal bundle between the B1 tracking channels and the shared discriminator scheduler.
// Dumps are fire-and-forget pulses; start/update are one-cycle strobes with no back-pressure.
interface b1_disc_sched_if #(
   parameter int NCH = 4,
   parameter int CHW = 2
);
   logic           rx_en;
   logic [NCH-1:0] rx_dump;
   logic           rx_ovr_clr;
   logic [CHW-1:0] tx_sel;
   logic           tx_eng_start;
   logic [NCH-1:0] tx_upd;
   logic [CHW-1:0] tx_upd_ch;
   logic           tx_busy;
   logic [NCH-1:0] tx_ovr;
   logic [15:0]    tx_ovr_cnt;
   logic [1:0]     dbg_state;

   // Handshake: rx_dump has no ready; each pulse lands in a one-deep per-channel
   // pending slot, and a pulse into an occupied slot is flagged as an overrun.
   modport master (
      output rx_en, rx_dump, rx_ovr_clr,
      input  tx_sel, tx_eng_start, tx_upd, tx_upd_ch, tx_busy, tx_ovr, tx_ovr_cnt, dbg_state
   );
   modport slave (
      input  rx_en, rx_dump, rx_ovr_clr,
      output tx_sel, tx_eng_start, tx_upd, tx_upd_ch, tx_busy, tx_ovr, tx_ovr_cnt, dbg_state
   );
endinterface

// File: rtl/b1_disc_sched.sv
// Round-robin scheduler sharing one non-pipelined discriminator engine between NCH channels.
// All outputs are registered; one operation is ISSUE, LAT-1 WAIT cycles, then WRITE.
module b1_disc_sched #(
   parameter int NCH = 4,
   parameter int CHW = 2,
   parameter int LAT = 20
) (
   input logic          rx_clk,
   input logic          rx_rst_n,
   b1_disc_sched_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_WRITE = 2'd3} state_t;

   state_t         state_q, state_d;
   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] ovr_q, ovr_d;
   logic [NCH-1:0] upd_q, upd_d;
   logic [CHW-1:0] sel_q, sel_d;
   logic [CHW-1:0] last_q, last_d;
   logic [CHW-1:0] upd_ch_q, upd_ch_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [15:0]    ovr_cnt_q, ovr_cnt_d;
   logic           start_q, start_d;
   logic           busy_q, busy_d;

   logic [NCH-1:0] issue_mask, ovr_hit;
   logic [CHW-1:0] winner, idx;
   logic           found, grant;
   logic [3:0]     ovr_k;
   logic [16:0]    ovr_sum;

   // First pending channel after the last one granted, wrapping modulo NCH.
   always_comb begin
      winner = last_q;
      found  = 1'b0;
      idx    = '0;
      for (int j = 1; j <= NCH; j++) begin
         idx = CHW'((int'(last_q) + j) % NCH);
         if (!found && pend_q[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // A dump landing on the channel being issued this cycle is a fresh request, not an overrun.
   always_comb begin
      issue_mask = '0;
      if (state_q == S_ISSUE) issue_mask[sel_q] = 1'b1;
      ovr_hit = bus.rx_dump & pend_q & ~issue_mask;
      pend_d  = (pend_q & ~issue_mask) | bus.rx_dump;
      ovr_k   = '0;
      for (int i = 0; i < NCH; i++) ovr_k = ovr_k + {3'b000, ovr_hit[i]};
      ovr_sum   = (bus.rx_ovr_clr ? 17'd0 : {1'b0, ovr_cnt_q}) + 17'(ovr_k);
      ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
      ovr_d     = (bus.rx_ovr_clr ? '0 : ovr_q) | ovr_hit;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      grant    = bus.rx_en && (pend_q != '0);
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d = S_ISSUE;
               sel_d   = winner;
            end
         end
         S_ISSUE: begin
            last_d  = sel_q;
            cnt_d   = 5'(LAT - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (grant) begin
               state_d = S_ISSUE;
               sel_d   = winner;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      start_d  = (state_d == S_ISSUE);
      busy_d   = (state_d != S_IDLE);
      upd_d    = '0;
      upd_ch_d = '0;
      if (state_d == S_WRITE) begin
         upd_d[sel_d] = 1'b1;
         upd_ch_d     = sel_d;
      end
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q   <= S_IDLE;
         pend_q    <= '0;
         ovr_q     <= '0;
         upd_q     <= '0;
         sel_q     <= '0;
         last_q    <= CHW'(NCH - 1);
         upd_ch_q  <= '0;
         cnt_q     <= '0;
         ovr_cnt_q <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         ovr_q     <= ovr_d;
         upd_q     <= upd_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         upd_ch_q  <= upd_ch_d;
         cnt_q     <= cnt_d;
         ovr_cnt_q <= ovr_cnt_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.tx_sel       = sel_q;
   assign bus.tx_eng_start = start_q;
   assign bus.tx_upd       = upd_q;
   assign bus.tx_upd_ch    = upd_ch_q;
   assign bus.tx_busy      = busy_q;
   assign bus.tx_ovr       = ovr_q;
   assign bus.tx_ovr_cnt   = ovr_cnt_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_b1_disc_sched.sv
// Bench for b1_disc_sched: timeline-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant order and latencies.
module tb_b1_disc_sched;
   localparam int NCH = 4;
   localparam int CHW = 2;
   localparam int LAT = 20;
   localparam int EW  = 30;

   logic rx_clk   = 1'b0;
   logic rx_rst_n = 1'b0;

   b1_disc_sched_if #(.NCH(NCH), .CHW(CHW)) bus();
   b1_disc_sched #(.NCH(NCH), .CHW(CHW), .LAT(LAT)) dut (
      .rx_clk   (rx_clk),
      .rx_rst_n (rx_rst_n),
      .bus      (bus)
   );

   always #5 rx_clk = ~rx_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: last start cycle plus pending/overrun bookkeeping
   bit             m_op;
   int             m_s;
   logic [CHW-1:0] m_win, m_last;
   logic [NCH-1:0] m_pend, m_ovr;
   int             m_cnt;
   bit             e_busy;
   logic [EW-1:0]  exp_q[$];

   int             st_cyc[$];
   int             st_ch[$];
   int             up_cyc[$];
   int             up_val[$];
   int             up_ch[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] p, input logic [CHW-1:0] last);
      int c;
      for (int j = 1; j <= NCH; j++) begin
         c = (int'(last) + j) % NCH;
         if (p[c]) return CHW'(c);
      end
      return last;
   endfunction

   function automatic void model_reset();
      m_op   = 1'b0;
      m_s    = 0;
      m_win  = '0;
      m_last = CHW'(NCH - 1);
      m_pend = '0;
      m_ovr  = '0;
      m_cnt  = 0;
      e_busy = 1'b0;
      exp_q.delete();
   endfunction

   function automatic void model_step();
      int             n, prev, k;
      bit             issuing, freep, grant, e_start;
      logic [CHW-1:0] w;
      logic [NCH-1:0] hit, e_upd;
      n       = cyc;
      prev    = cyc - 1;
      issuing = m_op && (prev == m_s);
      freep   = !m_op || (prev >= m_s + LAT);
      grant   = freep && bus.rx_en && (m_pend != '0);
      w       = rr_pick(m_pend, m_last);
      hit     = '0;
      k       = 0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.rx_dump[i] && m_pend[i] && !(issuing && int'(m_win) == i)) begin
            hit[i] = 1'b1;
            k++;
         end
      end
      if (issuing) m_pend[m_win] = 1'b0;
      m_pend = m_pend | bus.rx_dump;
      if (grant) begin
         m_op   = 1'b1;
         m_s    = n;
         m_win  = w;
         m_last = w;
      end
      if (bus.rx_ovr_clr) begin
         m_ovr = hit;
         m_cnt = k;
      end else begin
         m_ovr = m_ovr | hit;
         m_cnt = m_cnt + k;
      end
      if (m_cnt > 65535) m_cnt = 65535;
      e_start = m_op && (n == m_s);
      e_busy  = m_op && (n >= m_s) && (n <= m_s + LAT);
      e_upd   = '0;
      if (m_op && n == m_s + LAT) e_upd[m_win] = 1'b1;
      exp_q.push_back({e_start, m_win, e_upd, m_win, e_busy, m_ovr, 16'(m_cnt)});
   endfunction

   // Model advances on each edge; DUT outputs are compared 1 time unit later.
   always @(posedge rx_clk) begin
      logic [EW-1:0] e;
      cyc++;
      if (!rx_rst_n) begin
         model_reset();
      end else begin
         model_step();
         #1;
         e = exp_q.pop_front();
         chk("tx_eng_start", 32'(bus.tx_eng_start), 32'(e[29]));
         chk("tx_sel", 32'(bus.tx_sel), 32'(e[28:27]));
         chk("tx_upd", 32'(bus.tx_upd), 32'(e[26:23]));
         if (e[26:23] != 4'b0) chk("tx_upd_ch", 32'(bus.tx_upd_ch), 32'(e[22:21]));
         chk("tx_busy", 32'(bus.tx_busy), 32'(e[20]));
         chk("tx_ovr", 32'(bus.tx_ovr), 32'(e[19:16]));
         chk("tx_ovr_cnt", 32'(bus.tx_ovr_cnt), 32'(e[15:0]));
         if (bus.tx_eng_start) begin
            st_cyc.push_back(cyc);
            st_ch.push_back(int'(bus.tx_sel));
         end
         if (bus.tx_upd != '0) begin
            up_cyc.push_back(cyc);
            up_val.push_back(int'(bus.tx_upd));
            up_ch.push_back(int'(bus.tx_upd_ch));
         end
      end
   end

   task automatic clear_logs();
      st_cyc.delete(); st_ch.delete();
      up_cyc.delete(); up_val.delete(); up_ch.delete();
   endtask

   task automatic dump_once(input logic [NCH-1:0] mask, output int t);
      @(negedge rx_clk);
      bus.rx_dump = mask;
      t = cyc;
      @(negedge rx_clk);
      bus.rx_dump = '0;
   endtask

   task automatic ovr_clear();
      @(negedge rx_clk);
      bus.rx_ovr_clr = 1'b1;
      @(negedge rx_clk);
      bus.rx_ovr_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge rx_clk);
         if (!bus.tx_busy && m_pend == '0 && !e_busy) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: still busy=%0b after %0d cycles, want idle", bus.tx_busy, budget);
      end
   endtask

   task automatic apply_reset();
      @(negedge rx_clk);
      rx_rst_n = 1'b0;
      repeat (2) @(negedge rx_clk);
      rx_rst_n = 1'b1;
   endtask

   function automatic int count_ch(input int ch);
      int c = 0;
      foreach (st_ch[i]) if (st_ch[i] == ch) c++;
      return c;
   endfunction

   initial begin
      int t, t2;
      bus.rx_en      = 1'b1;
      bus.rx_dump    = '0;
      bus.rx_ovr_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge rx_clk);
      chk("rst_start", 32'(bus.tx_eng_start), 32'd0);
      chk("rst_sel", 32'(bus.tx_sel), 32'd0);
      chk("rst_upd", 32'(bus.tx_upd), 32'd0);
      chk("rst_busy", 32'(bus.tx_busy), 32'd0);
      chk("rst_ovr", 32'(bus.tx_ovr), 32'd0);
      chk("rst_ovr_cnt", 32'(bus.tx_ovr_cnt), 32'd0);
      rx_rst_n = 1'b1;
      repeat (5) @(negedge rx_clk);

      // single request on channel 2
      clear_logs();
      dump_once(4'b0100, t);
      wait_idle(100);
      chk("single_nstart", 32'(st_cyc.size()), 32'd1);
      if (st_cyc.size() >= 1 && up_cyc.size() >= 1) begin
         chk("single_start_lat", 32'(st_cyc[0] - t), 32'd2);
         chk("single_sel", 32'(st_ch[0]), 32'd2);
         chk("single_upd_lat", 32'(up_cyc[0] - st_cyc[0]), 32'd20);
         chk("single_upd", 32'(up_val[0]), 32'h4);
         chk("single_upd_ch", 32'(up_ch[0]), 32'd2);
      end
      chk("single_ovr", 32'(bus.tx_ovr), 32'd0);

      // all four at once right after reset: order 0,1,2,3
      apply_reset();
      clear_logs();
      dump_once(4'b1111, t);
      wait_idle(200);
      chk("all4_nstart", 32'(st_cyc.size()), 32'd4);
      chk("all4_nupd", 32'(up_cyc.size()), 32'd4);
      for (int i = 0; i < 4 && i < st_cyc.size() && i < up_cyc.size(); i++) begin
         chk("all4_ch", 32'(st_ch[i]), 32'(i));
         chk("all4_start_cyc", 32'(st_cyc[i] - t), 32'(2 + 21 * i));
         chk("all4_upd_lat", 32'(up_cyc[i] - st_cyc[i]), 32'd20);
         chk("all4_upd", 32'(up_val[i]), 32'(1 << i));
      end

      // fairness: last=1, then ch1/ch3 every 30 cycles
      dump_once(4'b0010, t);
      wait_idle(100);
      clear_logs();
      for (int p = 0; p < 4; p++) begin
         @(negedge rx_clk);
         bus.rx_dump = 4'b1010;
         @(negedge rx_clk);
         bus.rx_dump = '0;
         repeat (28) @(negedge rx_clk);
      end
      wait_idle(400);
      chk("fair_nstart_ge4", 32'(st_cyc.size() >= 4), 32'd1);
      if (st_ch.size() >= 4) begin
         chk("fair_g0", 32'(st_ch[0]), 32'd3);
         chk("fair_g1", 32'(st_ch[1]), 32'd1);
         chk("fair_g2", 32'(st_ch[2]), 32'd3);
         chk("fair_g3", 32'(st_ch[3]), 32'd1);
      end
      ovr_clear();
      chk("fair_clr_ovr", 32'(bus.tx_ovr), 32'd0);
      chk("fair_clr_cnt", 32'(bus.tx_ovr_cnt), 32'd0);

      // overrun: ch0 dumps twice while ch1 is serviced
      clear_logs();
      dump_once(4'b0010, t);
      repeat (4) @(negedge rx_clk);
      dump_once(4'b0001, t2);
      repeat (3) @(negedge rx_clk);
      dump_once(4'b0001, t2);
      chk("ovr_flag", 32'(bus.tx_ovr), 32'h1);
      chk("ovr_cnt", 32'(bus.tx_ovr_cnt), 32'd1);
      wait_idle(200);
      chk("ovr_ch0_once", 32'(count_ch(0)), 32'd1);
      ovr_clear();
      chk("ovr_clr_flag", 32'(bus.tx_ovr), 32'd0);
      chk("ovr_clr_cnt", 32'(bus.tx_ovr_cnt), 32'd0);

      // enable dropped mid-WAIT
      clear_logs();
      dump_once(4'b0100, t);
      repeat (6) @(negedge rx_clk);
      bus.rx_en = 1'b0;
      dump_once(4'b0001, t2);
      repeat (40) @(negedge rx_clk);
      chk("en_low_nupd", 32'(up_cyc.size()), 32'd1);
      chk("en_low_nstart", 32'(st_cyc.size()), 32'd1);
      bus.rx_en = 1'b1;
      wait_idle(100);
      chk("en_back_nstart", 32'(st_cyc.size()), 32'd2);
      if (st_ch.size() >= 2) chk("en_back_ch", 32'(st_ch[1]), 32'd0);

      // asynchronous reset mid-WAIT
      dump_once(4'b1000, t);
      repeat (6) @(negedge rx_clk);
      #2;
      rx_rst_n = 1'b0;
      #1;
      chk("async_rst_start", 32'(bus.tx_eng_start), 32'd0);
      chk("async_rst_sel", 32'(bus.tx_sel), 32'd0);
      chk("async_rst_upd", 32'(bus.tx_upd), 32'd0);
      chk("async_rst_busy", 32'(bus.tx_busy), 32'd0);
      repeat (2) @(negedge rx_clk);
      rx_rst_n = 1'b1;
      clear_logs();
      repeat (40) @(negedge rx_clk);
      chk("async_rst_no_upd", 32'(up_cyc.size()), 32'd0);
      chk("async_rst_no_start", 32'(st_cyc.size()), 32'd0);

      // dump on ch1 in its own ISSUE cycle
      clear_logs();
      dump_once(4'b0010, t);
      dump_once(4'b0010, t2);
      wait_idle(150);
      chk("same_nstart", 32'(st_cyc.size()), 32'd2);
      if (st_cyc.size() >= 2) begin
         chk("same_issue_cyc", 32'(st_cyc[0] - t2), 32'd0);
         chk("same_spacing", 32'(st_cyc[1] - st_cyc[0]), 32'd21);
         chk("same_ch", 32'(st_ch[1]), 32'd1);
      end
      chk("same_no_ovr", 32'(bus.tx_ovr), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge rx_clk);
         for (int c = 0; c < NCH; c++) bus.rx_dump[c] = ($urandom_range(0, 39) == 0);
         bus.rx_en      = ($urandom_range(0, 9) != 0);
         bus.rx_ovr_clr = ($urandom_range(0, 63) == 0);
      end
      @(negedge rx_clk);
      bus.rx_dump    = '0;
      bus.rx_ovr_clr = 1'b0;
      bus.rx_en      = 1'b1;
      wait_idle(300);

      // saturation: overrun every channel every cycle with grants blocked
      bus.rx_en = 1'b0;
      @(negedge rx_clk);
      bus.rx_dump = 4'b1111;
      repeat (16400) @(negedge rx_clk);
      bus.rx_dump = '0;
      @(negedge rx_clk);
      chk("sat_cnt", 32'(bus.tx_ovr_cnt), 32'hFFFF);
      chk("sat_flags", 32'(bus.tx_ovr), 32'hF);
      bus.rx_ovr_clr = 1'b1;
      bus.rx_dump    = 4'b1111;
      @(negedge rx_clk);
      bus.rx_ovr_clr = 1'b0;
      bus.rx_dump    = '0;
      chk("clr_vs_ovr_flags", 32'(bus.tx_ovr), 32'hF);
      chk("clr_vs_ovr_cnt", 32'(bus.tx_ovr_cnt), 32'd4);
      ovr_clear();
      chk("final_clr_cnt", 32'(bus.tx_ovr_cnt), 32'd0);
      bus.rx_en = 1'b1;
      wait_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      checks++;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/b1_disc_sched.md
Name: b1_disc_sched

Overview:
- Shares one non-pipelined discriminator engine (CORDIC divide/atan pair) between NCH B1 tracking channels.
- Each channel raises a one-cycle dump pulse when its accumulators close a PRN period. The scheduler queues the requests and grants them round-robin.
- For each grant it drives the operand-mux select and the engine start pulse, waits the fixed engine latency, then issues a one-hot update strobe. The strobe latches the result into that channel's discriminator register and triggers its loop-filter step.

Parameters:
- NCH, 4, number of tracking channels sharing the engine (2..8).
- CHW, 2, width of the channel index; must equal ceil(log2(NCH)).
- LAT, 20, engine latency in rx_clk cycles from start pulse to valid result (2..31).

Ports:
- rx_clk  in  1  system clock; all logic on the rising edge.
- rx_rst_n  in  1  asynchronous, active-low reset.
- rx_en  in  1  global enable; low blocks new grants.
- rx_dump  in  NCH  per-channel one-cycle dump pulse (accumulators valid).
- rx_ovr_clr  in  1  clears tx_ovr and tx_ovr_cnt.
- tx_sel  out  CHW  operand-mux select (channel index currently granted).
- tx_eng_start  out  1  one-cycle engine start pulse.
- tx_upd  out  NCH  one-hot, one-cycle result-latch / loop-filter strobe.
- tx_upd_ch  out  CHW  index matching tx_upd; valid while tx_upd is nonzero.
- tx_busy  out  1  high while in ISSUE, WAIT or WRITE.
- tx_ovr  out  NCH  sticky per-channel overrun flags.
- tx_ovr_cnt  out  16  saturating total overrun count.

Behaviour:
- Reset: all outputs 0; pending=0; state=IDLE; wait counter 0; round-robin pointer last=NCH-1, so channel 0 wins first.
- Pending register (NCH bits):
  - A dump on channel i at cycle t sets pending[i] visible at t+1.
  - A grant clears pending[i] in its ISSUE cycle.
  - A dump on i in the same cycle i is issued leaves pending[i]=1. This is a new request, not an overrun.
- Overrun:
  - A dump on channel i while pending[i]=1 and i is not being issued that cycle sets tx_ovr[i].
  - The same event increments tx_ovr_cnt, saturating at 16'hFFFF.
  - Pending stays 1; there is only one request slot per channel.
  - Simultaneous overruns on k channels add k to the count, saturating.
  - rx_ovr_clr clears both tx_ovr and tx_ovr_cnt. If a new overrun occurs in the same cycle, set and increment win: the flag stays set and the count becomes k.
- State machine, registered outputs:
  - IDLE: if rx_en and any pending bit, select the winner and go to ISSUE.
  - ISSUE (1 cycle): tx_eng_start=1 and tx_sel=winner. Clear that pending bit, set last=winner, load the wait counter with LAT-1, go to WAIT.
  - WAIT: tx_sel holds the winner. Decrement the counter; at 0 go to WRITE.
  - WRITE (1 cycle): tx_upd[winner]=1 and tx_upd_ch=winner. If rx_en and any pending bit, go directly to ISSUE; otherwise go to IDLE.
- Timing:
  - tx_upd asserts exactly LAT cycles after the tx_eng_start cycle.
  - Back-to-back start pulses are spaced LAT+1 cycles apart.
  - A dump reaches its first start no earlier than 2 cycles later (dump → pending → ISSUE).
- Round-robin: search channels last+1, last+2, … with wrap modulo NCH. The first pending bit found wins. A lone requester may win repeatedly.
- tx_sel is stable from ISSUE through WRITE; it holds its last value while in IDLE.
- rx_en low:
  - Never aborts an operation in flight. WAIT and WRITE complete and tx_upd is still issued.
  - From WRITE the FSM goes to IDLE.
  - Pending bits keep accumulating and overruns are still detected.
- Reset mid-operation: immediate asynchronous return to the reset state. No tx_upd is issued for the aborted operation, and pending requests are lost.
- Worst-case service: NCH*(LAT+1)+1 cycles. The dump period must exceed this, otherwise overruns are expected and flagged.

Test Plan:
- Single request: dump ch2 at cycle 10 → tx_eng_start and tx_sel=2 at cycle 12; tx_upd=4'b0100 and tx_upd_ch=2 at cycle 32 (LAT=20); then IDLE; tx_ovr=0.
- All four channels dump in the same cycle after reset → grants in order 0,1,2,3; start pulses at t+2, t+23, t+44, t+65; four tx_upd strobes, each LAT cycles after its start.
- Fairness: ch1 and ch3 dump every 30 cycles, last=1 → grants alternate 3,1,3,1; neither starves.
- Overrun: ch0 dumps twice while ch1 is being serviced → tx_ovr=4'b0001, tx_ovr_cnt=1, ch0 serviced once. Then rx_ovr_clr → flags and count 0. Also force 65536 overruns → count holds at FFFF.
- Enable/reset: drop rx_en during WAIT → tx_upd still fires, no further start while low, pending served when rx_en returns. Assert rx_rst_n low mid-WAIT → all outputs 0 asynchronously and no tx_upd afterwards.
- Same-cycle dump and issue on one channel → pending stays set, no overrun, second start follows LAT+1 cycles later.
